// File: rtl/serial_tx.sv
// serial_tx: framed parallel-to-serial line transmitter (start, data LSB first, optional even parity when SERIAL_TX_PARITY_EN is defined, stop)
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             VALID,
    output logic             READY,
    output logic             TXD,
    output logic             BUSY
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);
`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par, par_n;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic txd_n, busy_n, last;
    assign READY = state == IDLE;
    assign last  = cnt == CW'(CLKS_PER_BIT - 1);
    // next-state and next-output decode; TXD/BUSY are computed one cycle ahead so they can be flopped
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        txd_n   = TXD;
        busy_n  = BUSY;
`ifdef SERIAL_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: if (VALID) begin
                state_n = START;
                cnt_n   = '0;
                bcnt_n  = '0;
                shreg_n = DIN;
                txd_n   = 1'b0;
                busy_n  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                par_n   = ^DIN;
`endif
            end
            START: if (last) begin
                cnt_n   = '0;
                state_n = DATA;
                txd_n   = shreg[0];
            end else cnt_n = cnt + CW'(1);
            DATA: if (last) begin
                cnt_n = '0;
                if (bcnt == BW'(WIDTH - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_n = PARITY;
                    txd_n   = par;
`else
                    state_n = STOP;
                    txd_n   = 1'b1;
`endif
                end else begin
                    bcnt_n  = bcnt + BW'(1);
                    shreg_n = shreg >> 1;
                    txd_n   = shreg_n[0];
                end
            end else cnt_n = cnt + CW'(1);
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (last) begin
                cnt_n   = '0;
                state_n = STOP;
                txd_n   = 1'b1;
            end else cnt_n = cnt + CW'(1);
`endif
            STOP: if (last) begin
                cnt_n   = '0;
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end else cnt_n = cnt + CW'(1);
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end
    // state and output registers; reset abandons any frame in progress
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            bcnt  <= '0;
            shreg <= '0;
            TXD   <= 1'b1;
            BUSY  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bcnt  <= bcnt_n;
            shreg <= shreg_n;
            TXD   <= txd_n;
            BUSY  <= busy_n;
`ifdef SERIAL_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx; a frame-level model queues expected line levels per cycle
module tb_serial_tx;
    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int FB   = W + 2 + PB;
    localparam int FLEN = FB * CPB;
    logic CLK = 1'b0, RST = 1'b1, VALID = 1'b0, READY, TXD, BUSY;
    logic [W-1:0] DIN = '0;
    bit q[$];
    bit m_ready = 1'b1;
    bit chk_en = 1'b0;
    int acc_cnt = 0, checks = 0, errors = 0;
    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .VALID(VALID),
        .READY(READY), .TXD(TXD), .BUSY(BUSY)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", n, $time, a, e);
        end
    endtask
    // reference model: at an accept edge, queue the whole frame as one line level per clock
    always @(posedge CLK) begin
        if (RST) q.delete();
        else if (VALID && m_ready) begin
            for (int b = 0; b < FB; b++) begin
                bit v;
                v = b == 0 ? 1'b0 : b <= W ? DIN[b-1] : (PB == 1 && b == W + 1) ? ^DIN : 1'b1;
                repeat (CPB) q.push_back(v);
            end
            acc_cnt++;
        end
    end
    // monitor: compare the line, BUSY and READY against the head of the scoreboard every cycle
    always @(negedge CLK) begin
        bit eb;
        eb = q.size() > 0;
        if (chk_en) begin
            chk("busy", BUSY, eb);
            chk("ready", READY, !eb);
            chk("txd", TXD, eb ? q[0] : 1'b1);
        end
        if (eb) void'(q.pop_front());
        m_ready = !eb;
    end
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask
    task automatic send(input logic [W-1:0] d);
        int a;
        a = acc_cnt;
        VALID = 1'b1;
        DIN = d;
        for (int i = 0; i < 4 * FLEN && acc_cnt == a; i++) cyc();
        checks++;
        if (acc_cnt == a) begin
            errors++;
            $display("FAIL send_timeout: word %h not accepted, accepts %0d expected %0d", d, acc_cnt, a + 1);
        end
        VALID = 1'b0;
    endtask
    initial begin
        VALID = 1'b1;
        DIN = 8'hFF;
        cyc();
        chk_en = 1'b1;
        cyc();
        RST = 1'b0;
        VALID = 1'b0;
        repeat (3) cyc();
        send(8'hA5);
        DIN = 8'h3C;
        repeat (FLEN + 2) cyc();
        VALID = 1'b1;
        DIN = 8'h00;
        for (int i = 0; i < 4 * FLEN && acc_cnt < 2; i++) cyc();
        DIN = 8'hFF;
        for (int i = 0; i < 4 * FLEN && acc_cnt < 3; i++) cyc();
        VALID = 1'b0;
        repeat (FLEN + 2) cyc();
        send(8'h5A);
        repeat (14) cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        send(8'h81);
        repeat (FLEN + 2) cyc();
        send(8'h07);
        repeat (FLEN + 2) cyc();
        send(8'h03);
        repeat (FLEN + 2) cyc();
        for (int i = 0; i < 3000; i++) begin
            VALID = $urandom_range(0, 3) != 0;
            DIN = W'($urandom);
            RST = $urandom_range(0, 199) == 0;
            cyc();
        end
        RST = 1'b0;
        VALID = 1'b0;
        repeat (FLEN + 3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
